// File: rtl/led_blinker.sv
// Plays a blink code of iCode+1 LED pulses followed by a guard gap, with a
// one-deep pending slot so a request arriving mid-code plays right after it.
module led_blinker #(
  parameter logic [23:0] ON_CYC  = 24'd6_000_000,
  parameter logic [23:0] OFF_CYC = 24'd6_000_000,
  parameter logic [23:0] GAP_CYC = 24'd24_000_000
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       iIntReq,
  input  logic [2:0] iCode,
  output logic       oExtLed,
  output logic       oBusy,
  output logic       oPend,
  output logic [2:0] oDbgState
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ON   = 3'd1;
  localparam logic [2:0] ST_OFF  = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;

  logic [2:0]  rState, nxt_state;
  logic [23:0] rTmr, nxt_tmr;
  logic [2:0]  rBlk, nxt_blk;
  logic        rPend, nxt_pend;
  logic [2:0]  rPendCode, nxt_pend_code;
  logic        active;
  logic        gap_done;
  logic        start_direct;

  assign oDbgState = rState;

  assign active   = (rState == ST_ON) || (rState == ST_OFF) || (rState == ST_GAP);
  assign gap_done = (rState == ST_GAP) && (rTmr == GAP_CYC - 24'd1);
  // A request landing on the last gap cycle with an empty slot starts directly.
  assign start_direct = gap_done && !rPend && iIntReq;

  always_comb begin
    nxt_state     = rState;
    nxt_tmr       = rTmr;
    nxt_blk       = rBlk;
    nxt_pend      = rPend;
    nxt_pend_code = rPendCode;
    case (rState)
      ST_IDLE: begin
        if (iIntReq) begin
          nxt_state = ST_ON;
          nxt_blk   = iCode;
          nxt_tmr   = 24'd0;
        end
      end
      ST_ON: begin
        if (rTmr == ON_CYC - 24'd1) begin
          nxt_tmr = 24'd0;
          if (rBlk == 3'd0) begin
            nxt_state = ST_GAP;
          end else begin
            nxt_state = ST_OFF;
            nxt_blk   = rBlk - 3'd1;
          end
        end else begin
          nxt_tmr = rTmr + 24'd1;
        end
      end
      ST_OFF: begin
        if (rTmr == OFF_CYC - 24'd1) begin
          nxt_tmr   = 24'd0;
          nxt_state = ST_ON;
        end else begin
          nxt_tmr = rTmr + 24'd1;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          nxt_tmr = 24'd0;
          if (rPend) begin
            nxt_state = ST_ON;
            nxt_blk   = rPendCode;
            nxt_pend  = 1'b0;
          end else if (iIntReq) begin
            nxt_state = ST_ON;
            nxt_blk   = iCode;
          end else begin
            nxt_state = ST_IDLE;
          end
        end else begin
          nxt_tmr = rTmr + 24'd1;
        end
      end
      default: begin
        nxt_state     = ST_IDLE;
        nxt_tmr       = 24'd0;
        nxt_blk       = 3'd0;
        nxt_pend      = 1'b0;
        nxt_pend_code = 3'd0;
      end
    endcase
    // Capture after the gap handoff so a coincident request refills the slot.
    if (iIntReq && active && !start_direct) begin
      nxt_pend      = 1'b1;
      nxt_pend_code = iCode;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rState    <= ST_IDLE;
      rTmr      <= 24'd0;
      rBlk      <= 3'd0;
      rPend     <= 1'b0;
      rPendCode <= 3'd0;
      oExtLed   <= 1'b0;
      oBusy     <= 1'b0;
      oPend     <= 1'b0;
    end else begin
      rState    <= nxt_state;
      rTmr      <= nxt_tmr;
      rBlk      <= nxt_blk;
      rPend     <= nxt_pend;
      rPendCode <= nxt_pend_code;
      oExtLed   <= (nxt_state == ST_ON);
      oBusy     <= (nxt_state != ST_IDLE);
      oPend     <= nxt_pend;
    end
  end

endmodule

// File: doc/led_blinker.md
LED_BLINKER -- requirements
Module: led_blinker

Interface
REQ-001 Parameter ON_CYC, default 24'd6_000_000, LED-lit duration per blink in CLK cycles (0.25 s at 24 MHz); legal range 1..2^24-1.
REQ-002 Parameter OFF_CYC, default 24'd6_000_000, LED-dark duration between blinks of one code, in CLK cycles; legal range 1..2^24-1.
REQ-003 Parameter GAP_CYC, default 24'd24_000_000, LED-dark guard time after the last blink of a code, in CLK cycles; legal range 1..2^24-1.
REQ-004 CLK  input  1  system clock, all logic on rising edge.
REQ-005 RESETn  input  1  asynchronous, active-low reset.
REQ-006 iIntReq  input  1  one-cycle internal request pulse, e.g. a debounced button pulse.
REQ-007 iCode  input  3  blink code; blink count N = iCode + 1 (1..8), sampled only in the cycle iIntReq=1.
REQ-008 oExtLed  output  1  external LED drive, active high, registered.
REQ-009 oBusy  output  1  high while a code is being played, including its guard gap; registered.
REQ-010 oPend  output  1  high while a request is held in the one-deep pending slot; registered.

Function
REQ-011 FSM states: IDLE, ON, OFF, GAP; 24-bit cycle timer rTmr; 3-bit blink counter rBlk; pending flag and 3-bit pending code.
REQ-012 IDLE with iIntReq=1: next edge enters ON, loads rBlk=iCode, clears rTmr; oExtLed=1 and oBusy=1 from that edge (1-cycle latency).
REQ-013 ON: oExtLed=1; when rTmr==ON_CYC-1, clear rTmr; if rBlk==0 go GAP, else go OFF and decrement rBlk; otherwise increment rTmr.
REQ-014 OFF: oExtLed=0; when rTmr==OFF_CYC-1, clear rTmr and go ON; otherwise increment rTmr.
REQ-015 GAP: oExtLed=0; when rTmr==GAP_CYC-1, clear rTmr; if pending set, go ON with rBlk=pending code and clear pending in the same edge (oBusy stays 1); else go IDLE, oBusy=0.
REQ-016 LED high time per blink is exactly ON_CYC cycles; dark time between blinks is exactly OFF_CYC cycles; total busy time for code c is (c+1)*ON_CYC + c*OFF_CYC + GAP_CYC cycles.
REQ-017 iIntReq=1 while oBusy=1 (any non-IDLE state) sets pending and stores iCode; a later request while pending is set overwrites the stored code (last request wins); oPend reflects the flag one cycle after the request.
REQ-018 iIntReq=1 in the same cycle GAP expires with pending already set: the current pending code starts, the new request becomes the pending code, and oPend stays 1.
REQ-019 iIntReq=1 in the same cycle GAP expires with no pending: the request is captured as pending and started in the same edge, i.e. ON with rBlk=iCode, and oPend stays 0.
REQ-020 iIntReq held high for multiple cycles is treated as one request per cycle; no edge detection is performed in this block.
REQ-021 rTmr never exceeds max(ON_CYC, OFF_CYC, GAP_CYC)-1; no wrap-around is reachable.
REQ-022 An illegal FSM encoding returns to IDLE on the next edge with oExtLed=0.

Reset
REQ-023 RESETn=0 immediately forces, regardless of CLK: state=IDLE, rTmr=0, rBlk=0, pending=0, pending code=0, oExtLed=0, oBusy=0, oPend=0.
REQ-024 Reset asserted mid-blink or mid-gap aborts the code and discards pending; after release, the block stays in IDLE until a new iIntReq.

Verification (bench parameters ON_CYC=4, OFF_CYC=3, GAP_CYC=6)
REQ-025 Reset release, no requests for 100 cycles -> oExtLed=0, oBusy=0, oPend=0 throughout.
REQ-026 iIntReq pulse, iCode=2 at cycle k -> oExtLed high for cycles k+1..k+4, k+8..k+11 and k+15..k+18; oBusy falls at k+25; exactly 3 rising edges on oExtLed.
REQ-027 iCode=0 request, then iCode=5 at cycle k+2, then iCode=1 at cycle k+3 -> oPend=1 from k+3; after the first gap exactly 2 blinks play (code 1), with no idle cycle between the codes.
REQ-028 Request with iCode=7 -> 8 blinks, oBusy width = 8*4 + 7*3 + 6 = 59 cycles.
REQ-029 RESETn pulsed low during the 2nd ON of code 3 with a pending request -> oExtLed, oBusy and oPend all 0 asynchronously; no blinks after release.
REQ-030 iIntReq coincident with the final GAP cycle, no pending -> new code starts on the next edge, oBusy never drops, oPend stays 0.
